pll_lock_reset: RTL and testbench
=================================

PLL_LOCK_RESET -- requirements
Module: pll_lock_reset

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning the depth of the locked-input synchronizer (legal range 2..4).
REQ-002 SHALL have parameter LOCK_CYCLES, default 1024, meaning the clk cycles locked must stay continuously high before reset release begins (legal ≥1).
REQ-003 SHALL have parameter RELEASE_CYCLES, default 16, meaning the extra clk cycles reset is held after the lock qualifies (legal ≥1).
REQ-004 SHALL have port clk, input, 1 bit: the PLL output clock (pllout); sole clock.
REQ-005 SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port locked, input, 1 bit: the PLL lock flag, asynchronous to clk.
REQ-007 SHALL have port lost_clr, input, 1 bit: synchronous clear of the loss flag and the loss counter.
REQ-008 SHALL have port sys_rstn, output, 1 bit: registered, active-low downstream reset.
REQ-009 SHALL have port lock_lost, output, 1 bit: sticky flag set when lock drops while in RUN.
REQ-010 SHALL have port loss_cnt, output, 8 bits: saturating count of lock drops seen in RUN.
REQ-011 SHALL have port state, output, 3 bits: current FSM encoding (WAIT_LOCK=0, STABLE=1, RELEASE=2, RUN=3).

Function
REQ-012 SHALL pass locked through a SYNC_STAGES flop chain to produce lock_s; no other logic reads locked directly.
REQ-013 SHALL implement FSM states WAIT_LOCK, STABLE, RELEASE and RUN with a single shared counter cnt, sized clog2(max(LOCK_CYCLES, RELEASE_CYCLES)) bits.
REQ-014 In WAIT_LOCK: if lock_s=1, go to STABLE with cnt=0; otherwise stay.
REQ-015 In STABLE: if lock_s=0, go to WAIT_LOCK; else if cnt==LOCK_CYCLES-1, go to RELEASE with cnt=0; else increment cnt.
REQ-016 In RELEASE: if lock_s=0, go to WAIT_LOCK; else if cnt==RELEASE_CYCLES-1, go to RUN; else increment cnt.
REQ-017 In RUN: if lock_s=0, go to WAIT_LOCK, set lock_lost, and increment loss_cnt; otherwise stay.
REQ-018 sys_rstn SHALL be a dedicated flop loaded with (next_state==RUN), so it changes on the same edge as the state.
REQ-019 Latency: if edge 1 is the first edge sampling locked=1 and locked stays high, sys_rstn SHALL rise after edge SYNC_STAGES+1+LOCK_CYCLES+RELEASE_CYCLES.
REQ-020 Latency: if edge 1 is the first edge sampling locked=0 in RUN, sys_rstn SHALL fall after edge SYNC_STAGES+1.
REQ-021 A lock_s dropout of any length in STABLE or RELEASE SHALL restart qualification from WAIT_LOCK, with no loss flag or counter change.
REQ-022 loss_cnt SHALL saturate at 255; lock_lost stays 1 until cleared.
REQ-023 lost_clr=1 SHALL zero lock_lost and loss_cnt on the next edge.
REQ-024 If lost_clr and a RUN lock loss occur on the same edge, the loss SHALL win: lock_lost=1 and loss_cnt=1.
REQ-025 sys_rstn SHALL never be high in any state other than RUN.

Reset
REQ-026 resetn=0 SHALL asynchronously force: sync chain=0, state=WAIT_LOCK, cnt=0, sys_rstn=0, lock_lost=0, loss_cnt=0.
REQ-027 resetn deassertion SHALL take effect on the next clk edge; resetn low mid-RELEASE or mid-RUN SHALL drop sys_rstn immediately, without waiting for a clock edge.

Verification (bench parameters SYNC_STAGES=2, LOCK_CYCLES=8, RELEASE_CYCLES=4)
REQ-028 locked raised and held -> sys_rstn rises exactly after edge 15; state sequence 0,1,2,3.
REQ-029 In RUN, locked dropped -> sys_rstn=0 after edge 3, state=0, lock_lost=1, loss_cnt=1.
REQ-030 locked pulsed low 1 cycle during STABLE at cnt=5 -> return to WAIT_LOCK; sys_rstn rises 15 edges after the re-lock sample; loss_cnt stays 0.
REQ-031 300 RUN lock-loss/re-lock cycles -> loss_cnt=255 (saturated); lost_clr pulse -> loss_cnt=0, lock_lost=0.
REQ-032 lost_clr asserted on the same edge as a RUN loss -> loss_cnt=1, lock_lost=1.
REQ-033 resetn pulsed low asynchronously during RUN (between clk edges) -> sys_rstn=0 within that pulse and all outputs at reset values; full 15-edge qualification repeats after release.

Source files
------------

// File: rtl/pll_lock_reset.sv
// rtl/pll_lock_reset.sv - PLL lock qualifier that holds the downstream reset until locked has stayed high long enough
module pll_lock_reset #(
    parameter int SYNC_STAGES    = 2,
    parameter int LOCK_CYCLES    = 1024,
    parameter int RELEASE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       locked,
    input  logic       lost_clr,
    output logic       sys_rstn,
    output logic       lock_lost,
    output logic [7:0] loss_cnt,
    output logic [2:0] state
);

    localparam int MAXC = (LOCK_CYCLES > RELEASE_CYCLES) ? LOCK_CYCLES : RELEASE_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_CYCLES - 1);
    localparam logic [CW-1:0] REL_LAST  = CW'(RELEASE_CYCLES - 1);

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        STABLE    = 3'd1,
        RELEASE   = 3'd2,
        RUN       = 3'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync;
    logic                   lock_s;
    state_t                 cur, nxt;
    logic [CW-1:0]          cnt, cnt_nxt;
    logic                   loss_evt;

    // locked is asynchronous to clk; only the last sync stage is used downstream
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], locked};
        end
    end

    assign lock_s = sync[SYNC_STAGES-1];

    always_comb begin
        nxt      = cur;
        cnt_nxt  = cnt;
        loss_evt = 1'b0;
        case (cur)
            WAIT_LOCK: begin
                if (lock_s) begin
                    nxt     = STABLE;
                    cnt_nxt = '0;
                end
            end
            STABLE: begin
                if (!lock_s) begin
                    nxt     = WAIT_LOCK;
                    cnt_nxt = '0;
                end else if (cnt == LOCK_LAST) begin
                    nxt     = RELEASE;
                    cnt_nxt = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            RELEASE: begin
                if (!lock_s) begin
                    nxt     = WAIT_LOCK;
                    cnt_nxt = '0;
                end else if (cnt == REL_LAST) begin
                    nxt = RUN;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            RUN: begin
                if (!lock_s) begin
                    nxt      = WAIT_LOCK;
                    cnt_nxt  = '0;
                    loss_evt = 1'b1;
                end
            end
            default: begin
                nxt     = WAIT_LOCK;
                cnt_nxt = '0;
            end
        endcase
    end

    // sys_rstn is loaded from nxt so it moves on the same edge as the state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cur      <= WAIT_LOCK;
            cnt      <= '0;
            sys_rstn <= 1'b0;
        end else begin
            cur      <= nxt;
            cnt      <= cnt_nxt;
            sys_rstn <= (nxt == RUN);
        end
    end

    // A loss on the same edge as lost_clr wins and restarts the count at one
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lock_lost <= 1'b0;
            loss_cnt  <= 8'd0;
        end else if (loss_evt) begin
            lock_lost <= 1'b1;
            if (lost_clr) begin
                loss_cnt <= 8'd1;
            end else if (loss_cnt != 8'hFF) begin
                loss_cnt <= loss_cnt + 8'd1;
            end
        end else if (lost_clr) begin
            lock_lost <= 1'b0;
            loss_cnt  <= 8'd0;
        end
    end

    assign state = cur;

endmodule

// File: tb/tb_pll_lock_reset.sv
// tb/tb_pll_lock_reset.sv - directed bench for pll_lock_reset (SYNC_STAGES=2, LOCK_CYCLES=8, RELEASE_CYCLES=4)
module tb_pll_lock_reset;

    logic       clk;
    logic       resetn;
    logic       locked;
    logic       lost_clr;
    logic       sys_rstn;
    logic       lock_lost;
    logic [7:0] loss_cnt;
    logic [2:0] state;

    int vectors = 0;
    int errs    = 0;
    logic [7:0] exp_cnt;

    pll_lock_reset #(
        .SYNC_STAGES   (2),
        .LOCK_CYCLES   (8),
        .RELEASE_CYCLES(4)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .locked   (locked),
        .lost_clr (lost_clr),
        .sys_rstn (sys_rstn),
        .lock_lost(lock_lost),
        .loss_cnt (loss_cnt),
        .state    (state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Edge n counts from the first edge that samples locked=1
    function automatic logic [31:0] exp_state(input int n);
        if (n <= 2)       return 32'd0;
        else if (n <= 10) return 32'd1;
        else if (n <= 14) return 32'd2;
        else              return 32'd3;
    endfunction

    task automatic qualify(input string tag, input bit skip1);
        for (int n = 1; n <= 15; n++) begin
            @(negedge clk);
            chk({tag, "_rstn"}, {31'd0, sys_rstn}, {31'd0, (n == 15)});
            if (!(skip1 && n == 1))
                chk({tag, "_state"}, {29'd0, state}, exp_state(n));
        end
    endtask

    task automatic lose(input string tag, input logic [7:0] expc, input bit clr);
        locked = 1'b0;
        for (int n = 1; n <= 3; n++) begin
            @(negedge clk);
            chk({tag, "_rstn"}, {31'd0, sys_rstn}, {31'd0, (n < 3)});
            chk({tag, "_state"}, {29'd0, state}, (n < 3) ? 32'd3 : 32'd0);
            if (n == 2) lost_clr = clr;
        end
        lost_clr = 1'b0;
        chk({tag, "_lost"}, {31'd0, lock_lost}, 32'd1);
        chk({tag, "_cnt"}, {24'd0, loss_cnt}, {24'd0, expc});
    endtask

    initial begin
        resetn   = 1'b0;
        locked   = 1'b0;
        lost_clr = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_rstn",  {31'd0, sys_rstn},  32'd0);
        chk("rst_state", {29'd0, state},     32'd0);
        chk("rst_lost",  {31'd0, lock_lost}, 32'd0);
        chk("rst_cnt",   {24'd0, loss_cnt},  32'd0);

        // first lock: release after edge 15
        resetn = 1'b1;
        locked = 1'b1;
        qualify("q0", 1'b0);

        // loss in RUN
        lose("loss1", 8'd1, 1'b0);
        lost_clr = 1'b1;
        @(negedge clk);
        lost_clr = 1'b0;
        chk("clr_lost", {31'd0, lock_lost}, 32'd0);
        chk("clr_cnt",  {24'd0, loss_cnt},  32'd0);

        // one-cycle dropout during STABLE with cnt=5
        locked = 1'b1;
        repeat (6) @(negedge clk);
        chk("stb_state", {29'd0, state}, 32'd1);
        locked = 1'b0;
        @(negedge clk);
        locked = 1'b1;
        qualify("q_drop", 1'b1);
        chk("drop_lost", {31'd0, lock_lost}, 32'd0);
        chk("drop_cnt",  {24'd0, loss_cnt},  32'd0);

        // 300 losses saturate the counter
        exp_cnt = 8'd0;
        for (int i = 0; i < 300; i++) begin
            exp_cnt = (exp_cnt == 8'hFF) ? 8'hFF : exp_cnt + 8'd1;
            lose("sat", exp_cnt, 1'b0);
            locked = 1'b1;
            qualify("sat_q", 1'b0);
        end
        chk("sat_final", {24'd0, loss_cnt}, 32'd255);
        lost_clr = 1'b1;
        @(negedge clk);
        lost_clr = 1'b0;
        chk("satclr_lost", {31'd0, lock_lost}, 32'd0);
        chk("satclr_cnt",  {24'd0, loss_cnt},  32'd0);

        // clear coinciding with a loss: loss wins, count restarts at 1
        lose("pre", 8'd1, 1'b0);
        locked = 1'b1;
        qualify("pre_q", 1'b0);
        lose("both", 8'd1, 1'b1);
        locked = 1'b1;
        qualify("both_q", 1'b0);
        chk("both_keep", {24'd0, loss_cnt}, 32'd1);

        // asynchronous reset pulse between edges while in RUN
        #2;
        chk("ar_pre", {31'd0, sys_rstn}, 32'd1);
        resetn = 1'b0;
        #1;
        chk("ar_rstn",  {31'd0, sys_rstn},  32'd0);
        chk("ar_state", {29'd0, state},     32'd0);
        chk("ar_lost",  {31'd0, lock_lost}, 32'd0);
        chk("ar_cnt",   {24'd0, loss_cnt},  32'd0);
        #1;
        resetn = 1'b1;
        qualify("q_ar", 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
